// File: rtl/datapath_pipe.sv
// datapath_pipe: two-stage ALU + shifter pipeline with a 2**M x N register file.
// Stage 0 reads operands and evaluates the ALU; stage 1 shifts, writes back and
// drives DATA_out / stateBits. A stage-1 write to a register read in stage 0 is a
// hazard.
// Build option: define DATAPATH_PIPE_FORWARD_EN to forward the stage-1 shifter
// output to stage 0 instead of stalling one cycle on a hazard.
module datapath_pipe #(
   parameter int N = 8,
   parameter int M = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [M-1:0] src_a,
   input  logic [M-1:0] src_b,
   input  logic [M-1:0] dst,
   input  logic         we,
   input  logic         in_sel,
   input  logic [3:0]   alu_op,
   input  logic [2:0]   shift_op,
   input  logic [N-1:0] DATA_in,
   output logic [N-1:0] DATA_out,
   output logic         out_valid,
   output logic [3:0]   stateBits
);

   localparam int DEPTH = 2 ** M;

   // ALU: returns {V, N, Z, C, result}
   function automatic logic [N+3:0] alu_f(input logic [N-1:0] a,
                                          input logic [N-1:0] b,
                                          input logic [3:0]   op);
      logic [N-1:0] y;
      logic [N:0]   sum;
      logic [N-1:0] res;
      logic         v;
      logic         c;
      case (op[2:1])
         2'b00:   y = {N{1'b0}};
         2'b01:   y = b;
         2'b10:   y = ~b;
         default: y = {N{1'b1}};
      endcase
      sum = {1'b0, a} + {1'b0, y} + {{N{1'b0}}, op[0]};
      if (op[3] == 1'b0) begin
         res = sum[N-1:0];
         c   = sum[N];
         v   = (a[N-1] == y[N-1]) && (sum[N-1] != a[N-1]);
      end else begin
         c = 1'b0;
         v = 1'b0;
         case (op[2:1])
            2'b00:   res = a & b;
            2'b01:   res = a | b;
            2'b10:   res = a ^ b;
            default: res = ~a;
         endcase
      end
      return {v, res[N-1], (res == {N{1'b0}}), c, res};
   endfunction

   // Shifter: shl/shr fill with zero, asr replicates the sign bit
   function automatic logic [N-1:0] shift_f(input logic [N-1:0] d,
                                            input logic [2:0]   op);
      logic [N-1:0] r;
      case (op)
         3'b001:  r = {d[N-2:0], 1'b0};
         3'b010:  r = {1'b0, d[N-1:1]};
         3'b011:  r = {N{1'b0}};
         3'b101:  r = {d[N-2:0], d[N-1]};
         3'b110:  r = {d[0], d[N-1:1]};
         3'b111:  r = {d[N-1], d[N-1:1]};
         default: r = d;
      endcase
      return r;
   endfunction

   logic [N-1:0] rf_r [DEPTH];

   logic         s1_valid_r;
   logic [N-1:0] s1_res_r;
   logic [3:0]   s1_flags_r;
   logic [M-1:0] s1_dst_r;
   logic         s1_we_r;
   logic [2:0]   s1_shop_r;

   logic [N-1:0] sh_s;
   logic         wb_en_s;
   logic         fwd_a_s;
   logic         fwd_b_s;
   logic         stall_s;
   logic         accept_s;
   logic [N-1:0] opa_s;
   logic [N-1:0] opb_s;
   logic [N+3:0] alu_s;

   assign sh_s     = shift_f(s1_res_r, s1_shop_r);
   assign wb_en_s  = s1_valid_r & s1_we_r;
   assign in_ready = rst_n & ~stall_s;
   assign accept_s = in_valid & in_ready;
   assign alu_s    = alu_f(opa_s, opb_s, alu_op);

   // Hazard detection and stall decision against the pending stage-1 write
   always_comb begin
      fwd_a_s = wb_en_s && !in_sel && (src_a == s1_dst_r);
      fwd_b_s = wb_en_s && (src_b == s1_dst_r);
`ifdef DATAPATH_PIPE_FORWARD_EN
      stall_s = 1'b0;
`else
      stall_s = fwd_a_s | fwd_b_s;
`endif
   end

   // Operand read with write-through of the value being written this cycle
   always_comb begin
      opa_s = {N{1'b0}};
      opb_s = {N{1'b0}};
      if (in_sel) begin
         opa_s = DATA_in;
      end else if (fwd_a_s) begin
         opa_s = sh_s;
      end else begin
         opa_s = rf_r[src_a];
      end
      if (fwd_b_s) begin
         opb_s = sh_s;
      end else begin
         opb_s = rf_r[src_b];
      end
   end

   // Register file: cleared by reset, written from stage 1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            rf_r[i] <= {N{1'b0}};
         end
      end else if (wb_en_s) begin
         rf_r[s1_dst_r] <= sh_s;
      end
   end

   // Stage-1 capture and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_res_r   <= {N{1'b0}};
         s1_flags_r <= 4'b0000;
         s1_dst_r   <= {M{1'b0}};
         s1_we_r    <= 1'b0;
         s1_shop_r  <= 3'b000;
         DATA_out   <= {N{1'b0}};
         out_valid  <= 1'b0;
         stateBits  <= 4'b0000;
      end else begin
         s1_valid_r <= accept_s;
         if (accept_s) begin
            s1_res_r   <= alu_s[N-1:0];
            s1_flags_r <= alu_s[N+3:N];
            s1_dst_r   <= dst;
            s1_we_r    <= we;
            s1_shop_r  <= shift_op;
         end
         out_valid <= s1_valid_r;
         if (s1_valid_r) begin
            DATA_out  <= sh_s;
            stateBits <= s1_flags_r;
         end
      end
   end

endmodule

// File: tb/tb_datapath_pipe.sv
// Directed bench for datapath_pipe (N=8, M=3). Outputs are captured on the
// falling edge into queues and compared with hand-computed values.
module tb_datapath_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] src_a, src_b, dst;
   logic       we, in_sel;
   logic [3:0] alu_op;
   logic [2:0] shift_op;
   logic [7:0] DATA_in;
   logic [7:0] DATA_out;
   logic       out_valid;
   logic [3:0] stateBits;

`ifdef DATAPATH_PIPE_FORWARD_EN
   localparam int HAZ_STALL = 0;
`else
   localparam int HAZ_STALL = 1;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [7:0] oq_data [$];
   logic [3:0] oq_flags [$];
   int         oq_cyc [$];

   datapath_pipe #(.N(8), .M(3)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .src_a(src_a), .src_b(src_b), .dst(dst), .we(we), .in_sel(in_sel),
      .alu_op(alu_op), .shift_op(shift_op), .DATA_in(DATA_in),
      .DATA_out(DATA_out), .out_valid(out_valid), .stateBits(stateBits)
   );

   always #5 clk = ~clk;

   // Cycle counter
   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor
   always @(negedge clk) begin
      if (out_valid) begin
         oq_data.push_back(DATA_out);
         oq_flags.push_back(stateBits);
         oq_cyc.push_back(cyc);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_q();
      oq_data.delete();
      oq_flags.delete();
      oq_cyc.delete();
   endtask

   task automatic issue(input logic sel, input logic [7:0] d, input logic [2:0] a,
                        input logic [2:0] b, input logic [2:0] ds, input logic w,
                        input logic [3:0] op, input logic [2:0] sh,
                        output int stalls, output int acc);
      stalls   = 0;
      acc      = -1;
      in_valid = 1'b1;
      in_sel   = sel;
      DATA_in  = d;
      src_a    = a;
      src_b    = b;
      dst      = ds;
      we       = w;
      alu_op   = op;
      shift_op = sh;
      #1;
      while (!in_ready && stalls < 10) begin
         @(negedge clk);
         #1;
         stalls++;
      end
      if (!in_ready) check_eq("ready_timeout", {31'd0, in_ready}, 32'd1);
      else acc = cyc;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain(input string tag, input int n);
      int t = 0;
      while (oq_data.size() < n && t < 20) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      check_eq({tag, "_cnt"}, oq_data.size(), n);
   endtask

   task automatic chk_out(input string tag, input int i, input logic [7:0] ed,
                          input logic [3:0] ef);
      if (i < oq_data.size()) begin
         check_eq({tag, "_data"}, {24'd0, oq_data[i]}, {24'd0, ed});
         check_eq({tag, "_flags"}, {28'd0, oq_flags[i]}, {28'd0, ef});
      end else begin
         check_eq({tag, "_missing"}, oq_data.size(), i + 1);
      end
   endtask

   // Read a register through the pipe: 0 + r[b]
   task automatic read_reg(input string tag, input logic [2:0] r, input logic [7:0] ed);
      int st, ac;
      clear_q();
      issue(1'b1, 8'h00, 3'd0, r, 3'd0, 1'b0, 4'b0010, 3'b000, st, ac);
      drain(tag, 1);
      if (oq_data.size() > 0) check_eq(tag, {24'd0, oq_data[0]}, {24'd0, ed});
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int s1, a1, s2, a2, s3, a3, n0;
      rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; DATA_in = 8'h00;
      src_a = 3'd0; src_b = 3'd0; dst = 3'd0; we = 1'b0;
      alu_op = 4'b0000; shift_op = 3'b000;

      // Reset state
      repeat (2) @(negedge clk);
      in_valid = 1'b1;
      #1;
      check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("rst_data_out", {24'd0, DATA_out}, 32'd0);
      check_eq("rst_state", {28'd0, stateBits}, 32'd0);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("rel_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);

      // r1 = 0x0F, then r2 = r1 + r1 back-to-back (hazard on both operands)
      clear_q();
      issue(1'b1, 8'h0F, 3'd0, 3'd0, 3'd1, 1'b1, 4'b0000, 3'b000, s1, a1);
      issue(1'b0, 8'h00, 3'd1, 3'd1, 3'd2, 1'b1, 4'b0010, 3'b000, s2, a2);
      drain("fwd", 2);
      check_eq("fwd_stall1", s1, 0);
      check_eq("fwd_stall2", s2, HAZ_STALL);
      check_eq("fwd_acc_gap", a2 - a1, 1 + HAZ_STALL);
      chk_out("fwd_r1", 0, 8'h0F, 4'b0000);
      chk_out("fwd_r2", 1, 8'h1E, 4'b0000);
      if (oq_cyc.size() > 0) check_eq("latency", oq_cyc[0] - a1, 2);
      read_reg("rd_r2", 3'd2, 8'h1E);

      // Signed overflow: 0x7F + r3(0x01)
      clear_q();
      issue(1'b1, 8'h01, 3'd0, 3'd0, 3'd3, 1'b1, 4'b0000, 3'b000, s1, a1);
      issue(1'b1, 8'h7F, 3'd0, 3'd3, 3'd0, 1'b0, 4'b0010, 3'b000, s2, a2);
      drain("ovf", 2);
      check_eq("ovf_stall", s2, HAZ_STALL);
      chk_out("ovf", 1, 8'h80, 4'b1100);

      // Carry / zero, logic ops and subtraction against r1 = 0x0F
      clear_q();
      issue(1'b1, 8'hFF, 3'd0, 3'd0, 3'd0, 1'b0, 4'b0001, 3'b000, s1, a1);
      issue(1'b1, 8'hF0, 3'd0, 3'd1, 3'd0, 1'b0, 4'b1000, 3'b000, s1, a1);
      issue(1'b1, 8'hF0, 3'd0, 3'd1, 3'd0, 1'b0, 4'b1010, 3'b000, s1, a1);
      issue(1'b1, 8'hF0, 3'd0, 3'd1, 3'd0, 1'b0, 4'b1110, 3'b000, s1, a1);
      issue(1'b1, 8'h10, 3'd0, 3'd1, 3'd0, 1'b0, 4'b0101, 3'b000, s1, a1);
      issue(1'b1, 8'h00, 3'd0, 3'd1, 3'd0, 1'b0, 4'b0110, 3'b000, s1, a1);
      drain("alu", 6);
      chk_out("inc_ff", 0, 8'h00, 4'b0011);
      chk_out("and", 1, 8'h00, 4'b0010);
      chk_out("or", 2, 8'hFF, 4'b0100);
      chk_out("not", 3, 8'h0F, 4'b0000);
      chk_out("sub", 4, 8'h01, 4'b0001);
      chk_out("dec0", 5, 8'hFF, 4'b0100);

      // Shifter on 0x81
      clear_q();
      issue(1'b1, 8'h81, 3'd0, 3'd0, 3'd0, 1'b0, 4'b0000, 3'b101, s1, a1);
      issue(1'b1, 8'h81, 3'd0, 3'd0, 3'd0, 1'b0, 4'b0000, 3'b110, s1, a1);
      issue(1'b1, 8'h81, 3'd0, 3'd0, 3'd0, 1'b0, 4'b0000, 3'b111, s1, a1);
      issue(1'b1, 8'h81, 3'd0, 3'd0, 3'd0, 1'b0, 4'b0000, 3'b010, s1, a1);
      issue(1'b1, 8'h81, 3'd0, 3'd0, 3'd0, 1'b0, 4'b0000, 3'b011, s1, a1);
      issue(1'b1, 8'h81, 3'd0, 3'd0, 3'd0, 1'b0, 4'b0000, 3'b100, s1, a1);
      drain("shf", 6);
      chk_out("rotl", 0, 8'h03, 4'b0100);
      chk_out("rotr", 1, 8'hC0, 4'b0100);
      chk_out("asr", 2, 8'hC0, 4'b0100);
      chk_out("shr", 3, 8'h40, 4'b0100);
      chk_out("zero", 4, 8'h00, 4'b0100);
      chk_out("pass", 5, 8'h81, 4'b0100);

      // Write r6 = shl(0x81), then a non-hazard read (src_a ignored with in_sel)
      clear_q();
      issue(1'b1, 8'h81, 3'd0, 3'd0, 3'd6, 1'b1, 4'b0000, 3'b001, s1, a1);
      issue(1'b1, 8'h00, 3'd6, 3'd1, 3'd0, 1'b0, 4'b0010, 3'b000, s2, a2);
      drain("nohaz", 2);
      check_eq("nohaz_stall", s2, 0);
      chk_out("shl_wr", 0, 8'h02, 4'b0100);
      chk_out("nohaz_rd", 1, 8'h0F, 4'b0000);
      read_reg("rd_r6", 3'd6, 8'h02);

      // Bubble pattern 1,0,1: the bubble carries a write that must not land
      clear_q();
      issue(1'b1, 8'h55, 3'd0, 3'd0, 3'd7, 1'b1, 4'b0000, 3'b000, s1, a1);
      in_sel = 1'b1; DATA_in = 8'hAA; dst = 3'd7; we = 1'b1;
      @(negedge clk);
      issue(1'b1, 8'h33, 3'd0, 3'd0, 3'd5, 1'b1, 4'b0000, 3'b000, s3, a3);
      drain("bub", 2);
      check_eq("bub_acc_gap", a3 - a1, 2);
      if (oq_cyc.size() > 1) check_eq("bub_out_gap", oq_cyc[1] - oq_cyc[0], 2);
      read_reg("rd_r7", 3'd7, 8'h55);

      // Reset in the middle of three back-to-back instructions
      clear_q();
      issue(1'b1, 8'h91, 3'd0, 3'd0, 3'd4, 1'b1, 4'b0000, 3'b000, s1, a1);
      issue(1'b1, 8'h22, 3'd0, 3'd0, 3'd5, 1'b1, 4'b0000, 3'b000, s2, a2);
      #1;
      rst_n = 1'b0;
      in_valid = 1'b1; in_sel = 1'b1; DATA_in = 8'h66; dst = 3'd3; we = 1'b1;
      #1;
      n0 = oq_data.size();
      check_eq("mid_in_ready", {31'd0, in_ready}, 32'd0);
      check_eq("mid_data_out", {24'd0, DATA_out}, 32'd0);
      check_eq("mid_state", {28'd0, stateBits}, 32'd0);
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check_eq("mid_no_out", oq_data.size(), n0);
      read_reg("rd_r1_rst", 3'd1, 8'h00);
      read_reg("rd_r4_rst", 3'd4, 8'h00);
      read_reg("rd_r5_rst", 3'd5, 8'h00);
      read_reg("rd_r7_rst", 3'd7, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
